// File: rtl/wmul_pkg.sv
// Shared types and helpers for the time-shared 5x5 multiplier front end.
package wmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int W = 5;

  // Index width for n requesters; never below 1 so a 2-way arbiter still has an id bit.
  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans upward from last+1 with wraparound.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(last) + k) % N]) begin
        grant[(int'(last) + k) % N] = 1'b1;
        idx = IDW'((int'(last) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wallace_mul5x5.sv
// Existing combinational 5x5 unsigned multiplier shared by the arbiter.
module WallaceMul5x5 (
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic [9:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 5; i++) begin
      if (y[i]) p = p + ({5'b0, x} << i);
    end
  end

endmodule

// File: rtl/wmul_share_arbiter.sv
// Round-robin sharing of one WallaceMul5x5 among NREQ clients with a tagged
// valid/ready result channel.
module wmul_share_arbiter
  import wmul_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 5,
  parameter  int CNTW = 16,
  localparam int IDW  = idw_f(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [2*W-1:0]    res_p,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; res_p/res_id are held unchanged while res_valid is high and
  // res_ready is low.

  state_t          state;
  logic [W-1:0]    op_x, op_y;
  logic [IDW-1:0]  op_id, rr_last;
  logic [2*W-1:0]  prod;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            grant_en;
  logic            take;
  logic [W-1:0]    sel_x, sel_y;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .last  (rr_last),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  WallaceMul5x5 u_mul (
    .x (op_x),
    .y (op_y),
    .p (prod)
  );

  // A new operand set can only be taken when the result register is free or
  // being emptied in the same cycle.
  assign grant_en  = !rst && ((state == IDLE) || (state == HOLD && res_ready));
  assign take      = grant_en && arb_any;
  assign req_ready = grant_en ? arb_grant : '0;
  assign sel_x     = req_x[int'(arb_idx)*W +: W];
  assign sel_y     = req_y[int'(arb_idx)*W +: W];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_x      <= '0;
      op_y      <= '0;
      op_id     <= '0;
      rr_last   <= IDW'(NREQ - 1);
      res_valid <= 1'b0;
      res_id    <= '0;
      res_p     <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) state <= MUL;
        end
        MUL: begin
          res_p     <= prod;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            op_count  <= op_count + 1'b1;
            res_valid <= 1'b0;
            state     <= take ? MUL : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (take) begin
        op_x    <= sel_x;
        op_y    <= sel_y;
        op_id   <= arb_idx;
        rr_last <= arb_idx;
      end
    end
  end

endmodule

// File: tb/tb_wmul_share_arbiter.sv
// Directed bench for wmul_share_arbiter with a result scoreboard; built with
// CNTW=3 so the completion counter wraps within a short run.
module tb_wmul_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 5;
  localparam int CNTW = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x, req_y;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [1:0]        res_id;
  logic [2*W-1:0]    res_p;
  logic              res_ready;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  logic [W-1:0]    x_r [NREQ];
  logic [W-1:0]    y_r [NREQ];
  logic [NREQ-1:0] hold_req;
  logic [11:0]     exp_q [$];
  int              grant_log [$];
  logic [CNTW-1:0] exp_count;
  int              checks, errors;
  int              n;
  int              exp_order [5] = '{0, 1, 2, 3, 0};

  wmul_share_arbiter #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_p     (res_p),
    .res_ready (res_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = x_r[i];
      req_y[i*W +: W] = y_r[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes just before the next rising edge, then advance to the
  // following falling edge; granted non-persistent requesters drop valid.
  task automatic tick();
    logic [NREQ-1:0] g;
    logic [11:0]     e;
    g = req_valid & req_ready;
    chk("grant_onehot0", 32'($onehot0(req_ready)), 1);
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        exp_q.push_back({2'(i), 10'(x_r[i]) * 10'(y_r[i])});
        grant_log.push_back(i);
      end
    end
    if (res_valid && res_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("result_id_p", {20'b0, res_id, res_p}, {20'b0, e});
      exp_count = exp_count + 1'b1;
    end
    @(negedge clk);
    req_valid = req_valid & ~(g & ~hold_req);
  endtask

  task automatic step();
    #1;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; exp_count = '0;
    rst = 1'b1; res_ready = 1'b0; hold_req = '0;
    for (int i = 0; i < NREQ; i++) begin x_r[i] = '0; y_r[i] = '0; end
    req_valid = 4'b0001;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_p", res_p, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single request 12*12
    x_r[0] = 5'd12; y_r[0] = 5'd12; req_valid = 4'b0001; res_ready = 1'b1;
    #1; chk("t1_grant", req_ready, 4'b0001);
    tick();
    #1; chk("t1_grant_once", req_ready, 0); chk("t1_busy", busy, 1);
    tick();
    #1; chk("t1_res_valid", res_valid, 1); chk("t1_res_p", res_p, 144); chk("t1_res_id", res_id, 0);
    tick();
    #1; chk("t1_op_count", op_count, 1); chk("t1_idle", busy, 0);

    // zero and max operands
    x_r[1] = 5'd0; y_r[1] = 5'd27; req_valid = 4'b0010;
    repeat (3) step();
    x_r[3] = 5'd31; y_r[3] = 5'd31; req_valid = 4'b1000;
    repeat (3) step();
    #1; chk("edge_op_count", op_count, exp_count); chk("edge_q_empty", exp_q.size(), 0);
    @(negedge clk);

    // backpressure with a pending requester
    res_ready = 1'b0; x_r[2] = 5'd30; y_r[2] = 5'd20; req_valid = 4'b0100;
    step(); step();
    x_r[1] = 5'd7; y_r[1] = 5'd7; req_valid = req_valid | 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_res_valid", res_valid, 1); chk("bp_res_p", res_p, 600);
      chk("bp_res_id", res_id, 2); chk("bp_no_grant", req_ready, 0); chk("bp_busy", busy, 1);
      tick();
    end
    res_ready = 1'b1;
    #1; chk("bp_accept_grant", req_ready, 4'b0010);
    tick();
    #1; chk("bp_mul_gap", res_valid, 0);
    tick();
    #1; chk("bp_next_p", res_p, 49); chk("bp_next_id", res_id, 1);
    tick();
    #1; chk("bp_op_count", op_count, exp_count);
    @(negedge clk);

    // reset during MUL, then all four continuously requesting
    x_r[0] = 5'd15; y_r[0] = 5'd5;  x_r[1] = 5'd9;  y_r[1] = 5'd5;
    x_r[2] = 5'd10; y_r[2] = 5'd10; x_r[3] = 5'd31; y_r[3] = 5'd31;
    hold_req = 4'b1111; req_valid = 4'b1111;
    step();
    #2; rst = 1'b1;
    #1;
    chk("mrst_res_valid", res_valid, 0); chk("mrst_res_p", res_p, 0);
    chk("mrst_busy", busy, 0); chk("mrst_op_count", op_count, 0); chk("mrst_req_ready", req_ready, 0);
    exp_q.delete(); grant_log.delete(); exp_count = '0;
    @(negedge clk);
    rst = 1'b0;
    #1; chk("mrst_first_grant", req_ready, 4'b0001);
    n = 0;
    while (n < 20 && grant_log.size() < 5) begin
      if (n > 0) #1;
      tick();
      n++;
    end
    chk("rr_grant_cycles", n, 9);
    req_valid = '0; hold_req = '0;
    repeat (4) step();
    chk("rr_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_grant_order", grant_log[i], exp_order[i]);
    #1; chk("rr_op_count", op_count, 5); chk("rr_q_empty", exp_q.size(), 0);
    @(negedge clk);

    // counter wrap: nine transactions from reset with CNTW=3
    rst = 1'b1; #1; @(negedge clk); rst = 1'b0; exp_count = '0;
    for (int t = 0; t < 9; t++) begin
      x_r[0] = 5'($urandom_range(0, 31)); y_r[0] = 5'($urandom_range(0, 31));
      req_valid = 4'b0001;
      repeat (3) step();
    end
    #1; chk("wrap_op_count", op_count, 1); chk("wrap_model_count", op_count, exp_count);
    chk("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wmul_share_arbiter.md
Name: wmul_share_arbiter

Overview:
- Shares one 5x5 Wallace-tree multiplier (WallaceMul5x5, combinational) among NREQ requesters.
- Round-robin arbitration; operands and product registered around the shared multiplier.
- Tagged result returned on a single valid/ready output channel.
- Sits between several small-arithmetic clients and the single multiplier instance, replacing per-client multipliers.

Parameters:
- NREQ, 4, number of requesters (2..8); ID width IDW = clog2(NREQ).
- W, 5, operand width; must match WallaceMul5x5, so only 5 is legal.
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  in  1  rising-edge clock; the single clock of the block.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request strobe.
- req_x  in  NREQ*W  operand X; requester i uses bits [i*W +: W].
- req_y  in  NREQ*W  operand Y, same packing.
- req_ready  out  NREQ  one-hot grant; a request transfers when req_valid[i] & req_ready[i].
- res_valid  out  1  result available.
- res_id  out  IDW  index of the requester that owns res_p.
- res_p  out  2*W  unsigned product x*y.
- res_ready  in  1  consumer accepts result when res_valid & res_ready.
- busy  out  1  high whenever state != IDLE.
- op_count  out  CNTW  results delivered since reset; wraps modulo 2^CNTW.

Behaviour:
- Reset (async, any time): state=IDLE, res_valid=0, res_id=0, res_p=0, op_count=0, rr_last=NREQ-1, internal operand regs=0. req_ready is 0 while rst is high.
- Any in-flight operation or held result is discarded on reset; op_count is not incremented for it.
- States:
  - IDLE: nothing in flight.
  - MUL: operands are registered and the multiplier is settling.
  - HOLD: res_valid=1, waiting for res_ready.
- Arbitration is combinational.
  - Scan from (rr_last+1) mod NREQ upward with wraparound; the first asserted req_valid wins.
  - req_ready is one-hot or zero.
  - Grant is allowed only in IDLE, or in HOLD in the same cycle res_ready=1.
- IDLE, with any req_valid: assert req_ready[g]. At the edge, latch op_x/op_y from slot g, set op_id=g, rr_last=g, and go to MUL.
- IDLE, no request: stay in IDLE.
- MUL: no grant. At the edge, res_p <= product of the shared multiplier (op_x, op_y), res_id <= op_id, res_valid <= 1, and go to HOLD.
- HOLD, res_ready=0: all outputs stay stable, no grant, stay in HOLD.
- HOLD, res_ready=1: op_count increments at the edge.
  - If a request is granted in the same cycle: go to MUL with new operands; res_valid drops to 0 for exactly the MUL cycle.
  - Otherwise: res_valid <= 0 and go to IDLE.
- Latency: grant edge T; res_valid is high in the cycle after edge T+1, i.e. 2 cycles.
- Peak throughput: 1 result per 2 cycles.
- rr_last updates only on an actual grant. Requesters must hold x/y/valid stable until granted; the block does not check this.
- Width: the product is unsigned, 2W bits, never truncated; 31*31 = 961 fits in 10 bits.
- Simultaneous requests: exactly one grant per grant cycle; the others wait.
  - Fairness: with all NREQ continuously requesting, each is granted once every NREQ grants.
- op_count wraps from 2^CNTW-1 to 0 with no flag.

Decomposition:
- Package wmul_pkg holds:
  - state enum {IDLE, MUL, HOLD};
  - constant W=5;
  - a clog2-based IDW helper function.
- Sub-module rr_arbiter (NREQ inputs; inputs req and last; output one-hot grant plus encoded index) is purely combinational and is reused.
- The multiplier is an instance of the existing WallaceMul5x5 (ports x, y, p), not re-implemented.

Test Plan:
- Single request: req0 x=12, y=12, res_ready=1.
  - Expected: req_ready[0] for 1 cycle; 2 cycles later res_valid with res_id=0, res_p=144; op_count=1.
- All four requesting continuously with operands (15,5), (9,5), (10,10), (31,31), res_ready=1.
  - Expected: grants in order 0,1,2,3,0; results 75, 45, 100, 961 with ids 0..3, one every 2 cycles.
- Backpressure: req2 x=30, y=20, res_ready held 0 for 5 cycles.
  - Expected: res_valid/res_p=600/res_id=2 stable the whole time, no grants, busy=1.
  - Then raise res_ready together with pending req1 (7,7): accept and grant happen in the same cycle; next result is 49, id 1.
- Zero and max operands: x=0, y=27 -> 0; x=31, y=31 -> 961.
- Reset mid-operation: assert rst asynchronously during MUL (between clock edges).
  - Expected: outputs clear immediately, op_count=0, rr_last=NREQ-1.
  - After release, with all requesting, req0 is granted first.
- Counter wrap: parameter CNTW=3, 9 transactions -> op_count reads 1.
